// File: rtl/spi_master.sv
// SPI initiator: one DATA_WIDTH-bit word per transfer, MSB first, ss active-high,
// sclk idle low, target shifts on sclk rise so miso is captured on sclk fall.
module spi_master #(
    parameter int CLK_DIV    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  ss,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso
);

    // state | meaning
    // IDLE  | bus quiet, waiting for start
    // LEAD  | ss asserted, first bit on mosi, sclk low for setup
    // HIGH  | sclk high; falling edge at expiry captures miso
    // LOW   | sclk low, next bit on mosi
    // TRAIL | last bit done, ss held before release
    // GAP   | ss low so the target sees a deselect before the next word

    localparam int              BW        = $clog2(DATA_WIDTH + 1);
    localparam logic [7:0]      HP_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TRAIL,
        GAP
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            hp_cnt;
    logic                  hp_zero;
    logic [BW-1:0]         bit_cnt;
    logic                  last_bit;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;

    assign hp_zero  = (hp_cnt == 8'd0);
    assign last_bit = (bit_cnt == LAST_BIT);
    // mosi is the MSB flop of the tx shifter; cleared whenever the bus is idle
    assign mosi     = tx_sr[DATA_WIDTH-1];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)   state_nxt = LEAD;
            LEAD:    if (hp_zero) state_nxt = HIGH;
            HIGH:    if (hp_zero) state_nxt = last_bit ? TRAIL : LOW;
            LOW:     if (hp_zero) state_nxt = HIGH;
            TRAIL:   if (hp_zero) state_nxt = GAP;
            GAP:     if (hp_zero) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            hp_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                hp_cnt <= HP_RELOAD;
            end else if (!hp_zero) begin
                hp_cnt <= hp_cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_data <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ss      <= 1'b0;
            sclk    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_sr   <= tx_data;
                        ss      <= 1'b1;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                LEAD, LOW: begin
                    if (hp_zero) sclk <= 1'b1;
                end
                HIGH: begin
                    if (hp_zero) begin
                        sclk    <= 1'b0;
                        rx_sr   <= {rx_sr[DATA_WIDTH-2:0], miso};
                        bit_cnt <= bit_cnt + BW'(1);
                        // last bit stays on mosi through TRAIL
                        if (!last_bit) tx_sr <= tx_sr << 1;
                    end
                end
                TRAIL: begin
                    if (hp_zero) begin
                        ss      <= 1'b0;
                        rx_data <= rx_sr;
                        done    <= 1'b1;
                        tx_sr   <= '0;
                    end
                end
                GAP: begin
                    if (hp_zero) busy <= 1'b0;
                end
                default: begin
                    sclk <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback, behavioural target, reset abort,
// start-while-busy, back-to-back words and CLK_DIV=1.
module tb_spi_master;

    logic       sys_clk = 1'b0;
    logic       rst     = 1'b0;
    logic       start4  = 1'b0;
    logic       start1  = 1'b0;
    logic [7:0] tx4     = 8'h00;
    logic [7:0] tx1     = 8'h00;
    logic [7:0] rx4, rx1;
    logic       busy4, done4, ss4, sclk4, mosi4, miso4;
    logic       busy1, done1, ss1, sclk1, mosi1;
    logic       loop    = 1'b1;
    logic       sel     = 1'b0;
    logic       clr     = 1'b0;
    logic [7:0] t_pre   = 8'h00;

    always #5 sys_clk = ~sys_clk;

    spi_master #(.CLK_DIV(4), .DATA_WIDTH(8)) dut4 (
        .sys_clk(sys_clk), .rst(rst), .start(start4), .tx_data(tx4),
        .rx_data(rx4), .busy(busy4), .done(done4), .ss(ss4),
        .sclk(sclk4), .mosi(mosi4), .miso(miso4)
    );

    spi_master #(.CLK_DIV(1), .DATA_WIDTH(8)) dut1 (
        .sys_clk(sys_clk), .rst(rst), .start(start1), .tx_data(tx1),
        .rx_data(rx1), .busy(busy1), .done(done1), .ss(ss1),
        .sclk(sclk1), .mosi(mosi1), .miso(1'b0)
    );

    // behavioural target: presents its MSB on each sclk rise and shifts mosi in
    logic [7:0] t_sr;
    logic       t_miso;
    int         t_cnt;
    assign miso4 = loop ? mosi4 : t_miso;

    wire m_sclk = sel ? sclk1 : sclk4;
    wire m_ss   = sel ? ss1   : ss4;
    wire m_busy = sel ? busy1 : busy4;
    wire m_done = sel ? done1 : done4;
    wire m_mosi = sel ? mosi1 : mosi4;
    wire [7:0] m_rx = sel ? rx1 : rx4;

    int         cyc, rises, falls, done_cnt, t_start, t_done, t_bfall;
    int         ss_hi, ss_lo_run, last_gap, bad_sclk;
    logic [7:0] mbits, rx_first;
    logic       p_sclk, p_ss, p_busy;

    always @(negedge sys_clk) begin
        if (clr) begin
            cyc <= 0; rises <= 0; falls <= 0; done_cnt <= 0;
            t_start <= 0; t_done <= 0; t_bfall <= 0;
            ss_hi <= 0; ss_lo_run <= 0; last_gap <= -1; bad_sclk <= 0;
            mbits <= 8'h00; rx_first <= 8'h00;
            t_sr <= t_pre; t_miso <= 1'b0; t_cnt <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_sclk && !p_sclk) begin
                rises <= rises + 1;
                mbits <= {mbits[6:0], m_mosi};
                if (!m_ss) bad_sclk <= bad_sclk + 1;
                if (!sel) begin
                    t_miso <= t_sr[7];
                    t_sr   <= {t_sr[6:0], m_mosi};
                    t_cnt  <= t_cnt + 1;
                end
            end
            if (!m_sclk && p_sclk) begin
                falls <= falls + 1;
                if (!m_ss) bad_sclk <= bad_sclk + 1;
            end
            if (m_busy && !p_busy) t_start <= cyc;
            if (!m_busy && p_busy) t_bfall <= cyc;
            if (m_done) begin
                done_cnt <= done_cnt + 1;
                t_done   <= cyc;
                if (done_cnt == 0) rx_first <= m_rx;
            end
            if (m_ss) ss_hi <= ss_hi + 1;
            if (!m_ss) ss_lo_run <= ss_lo_run + 1;
            if (m_ss && !p_ss) begin
                last_gap  <= ss_lo_run;
                ss_lo_run <= 0;
            end
        end
        p_sclk <= m_sclk;
        p_ss   <= m_ss;
        p_busy <= m_busy;
    end

    int checks = 0;
    int errs   = 0;

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic clear_stats(input logic s);
        sel = s;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (m_busy && n < lim) begin
            tick();
            n++;
        end
        if (m_busy) begin
            checks++; errs++;
            $display("FAIL wait_idle: busy still %b after %0d cycles, want 0", m_busy, lim);
        end
    endtask

    task automatic kick(input logic s, input logic [7:0] d);
        if (s) begin tx1 = d; start1 = 1'b1; end
        else   begin tx4 = d; start4 = 1'b1; end
        tick();
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        checks++; if ({ss4, sclk4, mosi4, busy4, done4} !== 5'b0) begin errs++; $display("FAIL reset_ctl4: got %b want 00000", {ss4, sclk4, mosi4, busy4, done4}); end
        checks++; if (rx4 !== 8'h00) begin errs++; $display("FAIL reset_rx4: got %h want 00", rx4); end
        checks++; if ({ss1, sclk1, mosi1, busy1, done1, rx1} !== 13'b0) begin errs++; $display("FAIL reset_dut1: got %h want 0", {ss1, sclk1, mosi1, busy1, done1, rx1}); end
        rst = 1'b1;
        tick();
        checks++; if ({ss4, sclk4, busy4} !== 3'b0) begin errs++; $display("FAIL reset_release: got %b want 000", {ss4, sclk4, busy4}); end
    endtask

    task automatic test_loopback();
        loop = 1'b1;
        clear_stats(1'b0);
        kick(1'b0, 8'hA5);
        wait_idle(200);
        checks++; if (mbits !== 8'hA5) begin errs++; $display("FAIL lb_mosi_bits: got %h want a5", mbits); end
        checks++; if (rises !== 8 || falls !== 8) begin errs++; $display("FAIL lb_pulses: got %0d/%0d want 8/8", rises, falls); end
        checks++; if (t_done - t_start !== 68) begin errs++; $display("FAIL lb_done_time: got %0d want 68", t_done - t_start); end
        checks++; if (t_bfall - t_start !== 72) begin errs++; $display("FAIL lb_busy_time: got %0d want 72", t_bfall - t_start); end
        checks++; if (rx4 !== 8'hA5) begin errs++; $display("FAIL lb_rx: got %h want a5", rx4); end
        checks++; if (ss_hi !== 68) begin errs++; $display("FAIL lb_ss_high: got %0d want 68", ss_hi); end
        checks++; if (done_cnt !== 1 || bad_sclk !== 0) begin errs++; $display("FAIL lb_done_cnt: got %0d/%0d want 1/0", done_cnt, bad_sclk); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        loop = 1'b1;
        clear_stats(1'b0);
        kick(1'b0, 8'h96);
        while (rises < 3 && n < 100) begin tick(); n++; end
        if (rises < 3) begin checks++; errs++; $display("FAIL rm_wait: rises %0d want 3", rises); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({ss4, sclk4, mosi4, busy4, done4} !== 5'b0) begin errs++; $display("FAIL rm_ctl: got %b want 00000", {ss4, sclk4, mosi4, busy4, done4}); end
        checks++; if (rx4 !== 8'h00) begin errs++; $display("FAIL rm_rx: got %h want 00", rx4); end
        repeat (5) tick();
        checks++; if (done_cnt !== 0 || ss4 !== 1'b0) begin errs++; $display("FAIL rm_no_done: got %0d/%b want 0/0", done_cnt, ss4); end
        rst = 1'b1;
        tick();
        clear_stats(1'b0);
        kick(1'b0, 8'h5A);
        wait_idle(200);
        checks++; if (rx4 !== 8'h5A || done_cnt !== 1 || rises !== 8) begin errs++; $display("FAIL rm_after: got %h/%0d/%0d want 5a/1/8", rx4, done_cnt, rises); end
    endtask

    task automatic test_target();
        loop  = 1'b0;
        t_pre = 8'h3C;
        clear_stats(1'b0);
        kick(1'b0, 8'hC3);
        wait_idle(200);
        checks++; if (rx4 !== 8'h3C) begin errs++; $display("FAIL tgt_master_rx: got %h want 3c", rx4); end
        checks++; if (t_sr !== 8'hC3) begin errs++; $display("FAIL tgt_target_rx: got %h want c3", t_sr); end
        checks++; if (t_cnt !== 8) begin errs++; $display("FAIL tgt_rdy_count: got %0d want 8", t_cnt); end
        loop = 1'b1;
    endtask

    task automatic test_start_busy();
        loop = 1'b1;
        clear_stats(1'b0);
        kick(1'b0, 8'h12);
        repeat (20) tick();
        kick(1'b0, 8'hFF);
        wait_idle(200);
        repeat (10) tick();
        checks++; if (rx4 !== 8'h12) begin errs++; $display("FAIL sb_rx: got %h want 12", rx4); end
        checks++; if (done_cnt !== 1 || rises !== 8) begin errs++; $display("FAIL sb_once: got %0d/%0d want 1/8", done_cnt, rises); end
        checks++; if (busy4 !== 1'b0) begin errs++; $display("FAIL sb_idle: got %b want 0", busy4); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        loop = 1'b1;
        clear_stats(1'b0);
        tx4 = 8'h01;
        start4 = 1'b1;
        tick();
        tx4 = 8'h80;
        while (done_cnt < 2 && n < 400) begin tick(); n++; end
        start4 = 1'b0;
        if (done_cnt < 2) begin checks++; errs++; $display("FAIL b2b_wait: done %0d want 2", done_cnt); end
        wait_idle(200);
        checks++; if (rx_first !== 8'h01) begin errs++; $display("FAIL b2b_rx1: got %h want 01", rx_first); end
        checks++; if (rx4 !== 8'h80) begin errs++; $display("FAIL b2b_rx2: got %h want 80", rx4); end
        checks++; if (last_gap !== 5) begin errs++; $display("FAIL b2b_gap: got %0d want 5", last_gap); end
        checks++; if (rises !== 16 || done_cnt !== 2 || ss_hi !== 136) begin errs++; $display("FAIL b2b_counts: got %0d/%0d/%0d want 16/2/136", rises, done_cnt, ss_hi); end
        checks++; if (bad_sclk !== 0) begin errs++; $display("FAIL b2b_sclk_ss_low: got %0d want 0", bad_sclk); end
    endtask

    task automatic test_div1();
        clear_stats(1'b1);
        kick(1'b1, 8'hFF);
        wait_idle(100);
        checks++; if (ss_hi !== 17) begin errs++; $display("FAIL d1_ss_high: got %0d want 17", ss_hi); end
        checks++; if (rx1 !== 8'h00) begin errs++; $display("FAIL d1_rx: got %h want 00", rx1); end
        checks++; if (t_done - t_start !== 17) begin errs++; $display("FAIL d1_done_time: got %0d want 17", t_done - t_start); end
        checks++; if (t_bfall - t_start !== 18) begin errs++; $display("FAIL d1_busy_time: got %0d want 18", t_bfall - t_start); end
        checks++; if (rises !== 8 || falls !== 8 || mbits !== 8'hFF) begin errs++; $display("FAIL d1_sclk: got %0d/%0d/%h want 8/8/ff", rises, falls, mbits); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_reset_mid();
        test_target();
        test_start_busy();
        test_back_to_back();
        test_div1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI initiator that drives the SPI target block on the same bus: ss, sclk and mosi out, miso in.
- Runs off sys_clk. Each transfer sends one DATA_WIDTH-bit word MSB-first on mosi and captures one DATA_WIDTH-bit word from miso at the same time.
- Bus convention matches our target: ss is active-high (target enabled while ss=1, its bit counter clears on ss falling); sclk idles low; target shifts on sclk rising edge.
- ss is deasserted between words, so the target bit counter restarts every transfer.

Parameters:
- CLK_DIV, 4, sys_clk cycles per sclk half-period; legal range 1..255.
- DATA_WIDTH, 8, bits per transfer.

Ports:
- sys_clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request a transfer; sampled only in IDLE.
- tx_data  input  DATA_WIDTH  word to send; captured in the cycle start is accepted.
- rx_data  output  DATA_WIDTH  last received word; updated only at transfer end.
- busy  output  1  high from start acceptance until the inter-word gap ends.
- done  output  1  one-cycle pulse when rx_data is updated.
- ss  output  1  target select, active-high.
- sclk  output  1  SPI clock, idle low.
- mosi  output  1  serial data out, MSB first.
- miso  input  1  serial data in.

Behaviour:
- Reset (rst=0, asynchronous):
  - ss=0, sclk=0, mosi=0, busy=0, done=0, rx_data=0.
  - Internal shift registers, counters and state cleared; FSM goes to IDLE.
  - Release is taken on a sys_clk edge.
  - Reset mid-transfer aborts immediately: no done pulse, rx_data=0.
- All outputs are registered, with no combinational path from inputs to outputs.
- Half-period counter: reloads to CLK_DIV-1 on every state entry and expires when it reaches 0. Each timed state therefore lasts exactly CLK_DIV cycles.
- FSM states: IDLE, LEAD, HIGH, LOW, TRAIL, GAP.
- IDLE:
  - ss=0, sclk=0, busy=0.
  - On start=1 at edge E0: tx shift <- tx_data, mosi <- tx_data[MSB], ss <- 1, busy <- 1, bit_cnt <- 0, go to LEAD.
- LEAD: on expiry, sclk <- 1, go to HIGH. The target samples mosi on this rising edge.
- HIGH: on expiry:
  - sclk <- 0.
  - rx shift <- {rx shift[DATA_WIDTH-2:0], miso}, using the miso value present before the edge. Miso is sampled at the falling edge because the target updates miso on the rising edge.
  - bit_cnt <- bit_cnt+1.
  - If bit_cnt was DATA_WIDTH-1, go to TRAIL. Otherwise mosi <- next bit (tx shift left by one) and go to LOW.
- LOW: on expiry, sclk <- 1, go to HIGH.
- TRAIL: on expiry, ss <- 0, rx_data <- rx shift, done <- 1 for exactly one cycle, mosi <- 0, go to GAP.
- GAP:
  - ss held low for CLK_DIV cycles, which guarantees the target sees an ss falling edge.
  - On expiry: busy <- 0, go to IDLE.
- Timing, with E0 = start acceptance edge:
  - sclk rising edges at E0 + (2k+1)·CLK_DIV, k = 0..DATA_WIDTH-1.
  - Last sclk falling edge at E0 + 2·DATA_WIDTH·CLK_DIV.
  - ss falls and done asserts at E0 + (2·DATA_WIDTH+1)·CLK_DIV.
  - busy falls at E0 + (2·DATA_WIDTH+2)·CLK_DIV.
  - With defaults: ss high for 68 cycles, done at E0+68, busy low at E0+72.
- start while busy=1 is ignored; tx_data changes during a transfer have no effect.
- start held high continuously gives back-to-back transfers. The next one is accepted in the first IDLE cycle, so the minimum ss-low time between words is CLK_DIV+1 cycles.
- Exactly DATA_WIDTH sclk pulses per transfer. No sclk activity while ss=0.
- CLK_DIV=1: sclk = sys_clk/2, and all states last one cycle.

Test Plan:
- Reset: drive rst=0 mid-transfer (after the 3rd sclk rise) -> ss, sclk, mosi, busy, done and rx_data go to 0 immediately, with no done pulse. After release, the next start runs a full clean transfer.
- Loopback (miso tied to mosi), CLK_DIV=4, tx_data=8'hA5 -> mosi bits 1,0,1,0,0,1,0,1 seen at sclk rising edges, 8 sclk pulses, done at E0+68, rx_data=8'hA5, busy low at E0+72.
- Against the spi_slave block, preloaded with 8'h3C, master tx_data=8'hC3 -> master rx_data=8'h3C, target spi_data_out=8'hC3, target data_rdy high after the 8th sclk rising edge.
- start pulsed during busy with tx_data=8'hFF, while a transfer of 8'h12 is in progress -> ignored; rx (loopback) = 8'h12, and exactly one done pulse.
- start held high, tx_data=8'h01 then 8'h80 -> two transfers. ss low for exactly 5 cycles between them; each shows 8 sclk pulses and one done.
- CLK_DIV=1, tx_data=8'hFF, miso=0 -> sclk toggles every cycle, ss high 17 cycles, rx_data=8'h00, done at E0+17.
